// File: rtl/plant_pkg.sv
// Shared defaults and helpers for the plant input conditioner.
package plant_pkg;

  localparam int PLANT_N_CH      = 8;
  localparam int PLANT_CNT_W     = 4;
  localparam int PLANT_PRESCALE  = 16;
  localparam int PLANT_DB_THRESH = 4;

  // Prescaler counter width; a single bit is kept even when PRESCALE is 1.
  function automatic int plant_pcnt_w(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/plant_debounce_ch.sv
// One conditioned channel: two-flop synchronizer, tick-paced debounce counter,
// clean level register and registered rise/fall pulses.
module plant_debounce_ch
  import plant_pkg::*;
#(
  parameter int CNT_W     = PLANT_CNT_W,
  parameter int DB_THRESH = PLANT_DB_THRESH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_THRESH - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign accept = tick && (sync_q2 != clean) && (cnt == CNT_LAST);

  // Any cycle where the synchronized input agrees with clean discards progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept && sync_q2;
      fall <= accept && !sync_q2;
      if (sync_q2 == clean) begin
        cnt <= '0;
      end else if (accept) begin
        clean <= sync_q2;
        cnt   <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/plant_input_conditioner.sv
// Pad input front end: shared debounce prescaler, per-channel conditioners,
// sticky edge flags (only when PLANT_EDGE_LATCH_EN is defined) and io_oeb tie-off.
module plant_input_conditioner
  import plant_pkg::*;
#(
  parameter int N_CH      = PLANT_N_CH,
  parameter int CNT_W     = PLANT_CNT_W,
  parameter int PRESCALE  = PLANT_PRESCALE,
  parameter int DB_THRESH = PLANT_DB_THRESH
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            en_i,
  input  logic [N_CH-1:0] raw_i,
  input  logic [N_CH-1:0] clr_i,
  output logic [N_CH-1:0] clean_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] sticky_o,
  output logic            tick_o,
  output logic [N_CH-1:0] io_oeb_o
);

  localparam int            PW         = plant_pcnt_w(PRESCALE);
  localparam logic [PW-1:0] PCNT_LAST  = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  // Reset gating keeps tick_o low during reset even when PRESCALE is 1.
  assign tick   = en_i && wb_rst_ni && (pcnt == PCNT_LAST);
  assign tick_o = tick;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pcnt <= '0;
    end else if (!en_i || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    plant_debounce_ch #(
      .CNT_W    (CNT_W),
      .DB_THRESH(DB_THRESH)
    ) u_ch (
      .clk  (wb_clk_i),
      .rst_n(wb_rst_ni),
      .raw  (raw_i[g]),
      .tick (tick),
      .clean(clean_o[g]),
      .rise (rise_o[g]),
      .fall (fall_o[g])
    );
  end

`ifdef PLANT_EDGE_LATCH_EN
  // Set has priority over a same-cycle clear so no edge is ever lost.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sticky_o <= '0;
    end else begin
      sticky_o <= (sticky_o & ~clr_i) | rise_o | fall_o;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^clr_i;
  assign sticky_o   = '0;
`endif

  assign io_oeb_o = '1;

endmodule
